// File: rtl/ext_mem_loader.sv
// ext_mem_loader: host-side initiator for the CPU's external memory ports.
// Decodes a byte-stream command protocol (load IMEM, load DMEM, run, dump
// DMEM) and drives word writes, word reads and the CPU enable.
// Frame layout: opcode, CNT (16b LE), START (16b LE), then payload bytes.
// Responses: 0xA5 after every valid command, 0xEE for a bad opcode, plus
// 8 bytes per word (LSB first) for a dump.
module ext_mem_loader #(
    parameter int IMEM_AW = 9,
    parameter int DMEM_AW = 10
) (
    input  logic        clk,
    input  logic        arst_n,
    // host byte stream in
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    // response byte stream out
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    // instruction memory port
    output logic [63:0] imem_addr,
    output logic        imem_wen,
    output logic        imem_ren,
    output logic [31:0] imem_wdata,
    // data memory port
    output logic [63:0] dmem_addr,
    output logic        dmem_wen,
    output logic        dmem_ren,
    output logic [63:0] dmem_wdata,
    input  logic [63:0] dmem_rdata,
    // run control and status
    output logic        cpu_enable,
    output logic        busy,
    output logic        err
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_LOAD,
        ST_WRITE,
        ST_RUN,
        ST_DUMP_RD,
        ST_DUMP_WAIT,
        ST_DUMP_TX,
        ST_ACK
    } state_t;

    localparam logic [2:0] OP_LOAD_IMEM = 3'd1;
    localparam logic [2:0] OP_LOAD_DMEM = 3'd2;
    localparam logic [2:0] OP_RUN       = 3'd3;
    localparam logic [2:0] OP_DUMP      = 3'd4;

    localparam logic [7:0] RESP_ACK = 8'hA5;
    localparam logic [7:0] RESP_BAD = 8'hEE;

    localparam logic [IMEM_AW-1:0] IMEM_ONE = 1;
    localparam logic [DMEM_AW-1:0] DMEM_ONE = 1;

    state_t             state_reg;
    logic [2:0]         op_reg;          // low bits of the accepted opcode (1..4)
    logic [1:0]         hdr_idx_reg;     // which header byte comes next
    logic [15:0]        cnt_reg;         // CNT as received
    logic [7:0]         start_lo_reg;    // START[7:0], joined with byte 4
    logic [15:0]        remain_reg;      // words / cycles still to go
    logic [IMEM_AW-1:0] imem_idx_reg;    // IMEM word index, wraps naturally
    logic [DMEM_AW-1:0] dmem_idx_reg;    // DMEM word index, wraps naturally
    logic [2:0]         byte_idx_reg;    // byte lane within the current word
    logic [63:0]        word_reg;        // assembly / transmit shift buffer

    logic               s_accept;
    logic               m_accept;
    logic               last_byte;
    logic [63:0]        word_next;
    logic [IMEM_AW-1:0] imem_idx_inc;
    logic [DMEM_AW-1:0] dmem_idx_inc;

    // Byte acceptance: a pending bad-opcode response must drain before the
    // next opcode is taken, so responses never reorder. Held off in reset.
    assign s_ready = arst_n &&
                     (((state_reg == ST_IDLE) && !m_valid) ||
                      (state_reg == ST_HDR) ||
                      (state_reg == ST_LOAD));

    assign s_accept = s_valid && s_ready;
    assign m_accept = m_valid && m_ready;
    assign busy     = (state_reg != ST_IDLE);
    assign imem_ren = 1'b0;

    assign last_byte    = (op_reg == OP_LOAD_DMEM) ? (byte_idx_reg == 3'd7)
                                                   : (byte_idx_reg == 3'd3);
    assign imem_idx_inc = imem_idx_reg + IMEM_ONE;
    assign dmem_idx_inc = dmem_idx_reg + DMEM_ONE;

    // Little-endian word assembly: the incoming byte replaces the lane
    // selected by byte_idx_reg, every other lane keeps its value.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign word_next[gi*8 +: 8] = (byte_idx_reg == 3'(gi)) ? s_data
                                                                   : word_reg[gi*8 +: 8];
        end
    endgenerate

    // Command FSM with registered strobes, addresses, data and response byte.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_reg    <= ST_IDLE;
            op_reg       <= 3'd0;
            hdr_idx_reg  <= 2'd0;
            cnt_reg      <= 16'd0;
            start_lo_reg <= 8'd0;
            remain_reg   <= 16'd0;
            imem_idx_reg <= '0;
            dmem_idx_reg <= '0;
            byte_idx_reg <= 3'd0;
            word_reg     <= 64'd0;
            m_valid      <= 1'b0;
            m_data       <= 8'd0;
            imem_addr    <= 64'd0;
            imem_wen     <= 1'b0;
            imem_wdata   <= 32'd0;
            dmem_addr    <= 64'd0;
            dmem_wen     <= 1'b0;
            dmem_ren     <= 1'b0;
            dmem_wdata   <= 64'd0;
            cpu_enable   <= 1'b0;
            err          <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (m_accept) begin
                        m_valid <= 1'b0;
                    end
                    if (s_accept) begin
                        if (s_data inside {[8'h01:8'h04]}) begin
                            op_reg      <= s_data[2:0];
                            hdr_idx_reg <= 2'd0;
                            state_reg   <= ST_HDR;
                        end else begin
                            // Only the opcode byte is consumed; stay in IDLE.
                            err     <= 1'b1;
                            m_valid <= 1'b1;
                            m_data  <= RESP_BAD;
                        end
                    end
                end

                ST_HDR: begin
                    if (s_accept) begin
                        hdr_idx_reg <= hdr_idx_reg + 2'd1;
                        case (hdr_idx_reg)
                            2'd0: cnt_reg[7:0]  <= s_data;
                            2'd1: cnt_reg[15:8] <= s_data;
                            2'd2: start_lo_reg  <= s_data;
                            default: begin
                                // Header complete: START = {s_data, start_lo_reg}.
                                remain_reg   <= cnt_reg;
                                imem_idx_reg <= IMEM_AW'({s_data, start_lo_reg});
                                dmem_idx_reg <= DMEM_AW'({s_data, start_lo_reg});
                                byte_idx_reg <= 3'd0;
                                word_reg     <= 64'd0;
                                if (cnt_reg == 16'd0) begin
                                    m_valid   <= 1'b1;
                                    m_data    <= RESP_ACK;
                                    state_reg <= ST_ACK;
                                end else if (op_reg == OP_RUN) begin
                                    cpu_enable <= 1'b1;
                                    state_reg  <= ST_RUN;
                                end else if (op_reg == OP_DUMP) begin
                                    dmem_ren  <= 1'b1;
                                    dmem_addr <= 64'({DMEM_AW'({s_data, start_lo_reg}), 3'b000});
                                    state_reg <= ST_DUMP_RD;
                                end else begin
                                    state_reg <= ST_LOAD;
                                end
                            end
                        endcase
                    end
                end

                ST_LOAD: begin
                    if (s_accept) begin
                        word_reg     <= word_next;
                        byte_idx_reg <= byte_idx_reg + 3'd1;
                        if (last_byte) begin
                            byte_idx_reg <= 3'd0;
                            state_reg    <= ST_WRITE;
                            if (op_reg == OP_LOAD_DMEM) begin
                                dmem_wen   <= 1'b1;
                                dmem_addr  <= 64'({dmem_idx_reg, 3'b000});
                                dmem_wdata <= word_next;
                            end else begin
                                imem_wen   <= 1'b1;
                                imem_addr  <= 64'({imem_idx_reg, 2'b00});
                                imem_wdata <= word_next[31:0];
                            end
                        end
                    end
                end

                ST_WRITE: begin
                    // The strobe was raised on entry, so it lasts exactly this cycle.
                    imem_wen     <= 1'b0;
                    dmem_wen     <= 1'b0;
                    imem_idx_reg <= imem_idx_inc;
                    dmem_idx_reg <= dmem_idx_inc;
                    remain_reg   <= remain_reg - 16'd1;
                    word_reg     <= 64'd0;
                    if (remain_reg == 16'd1) begin
                        m_valid   <= 1'b1;
                        m_data    <= RESP_ACK;
                        state_reg <= ST_ACK;
                    end else begin
                        state_reg <= ST_LOAD;
                    end
                end

                ST_RUN: begin
                    // cpu_enable was raised on entry; one RUN cycle per count.
                    remain_reg <= remain_reg - 16'd1;
                    if (remain_reg == 16'd1) begin
                        cpu_enable <= 1'b0;
                        m_valid    <= 1'b1;
                        m_data     <= RESP_ACK;
                        state_reg  <= ST_ACK;
                    end
                end

                ST_DUMP_RD: begin
                    dmem_ren  <= 1'b0;
                    state_reg <= ST_DUMP_WAIT;
                end

                ST_DUMP_WAIT: begin
                    // Read data is valid the cycle after the read strobe.
                    word_reg     <= dmem_rdata;
                    m_valid      <= 1'b1;
                    m_data       <= dmem_rdata[7:0];
                    byte_idx_reg <= 3'd0;
                    state_reg    <= ST_DUMP_TX;
                end

                ST_DUMP_TX: begin
                    if (m_accept) begin
                        if (byte_idx_reg == 3'd7) begin
                            dmem_idx_reg <= dmem_idx_inc;
                            remain_reg   <= remain_reg - 16'd1;
                            if (remain_reg == 16'd1) begin
                                m_data    <= RESP_ACK;
                                state_reg <= ST_ACK;
                            end else begin
                                m_valid   <= 1'b0;
                                dmem_ren  <= 1'b1;
                                dmem_addr <= 64'({dmem_idx_inc, 3'b000});
                                state_reg <= ST_DUMP_RD;
                            end
                        end else begin
                            byte_idx_reg <= byte_idx_reg + 3'd1;
                            word_reg     <= word_reg >> 8;
                            m_data       <= word_reg[15:8];
                        end
                    end
                end

                ST_ACK: begin
                    if (m_accept) begin
                        m_valid   <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ext_mem_loader.sv
// Directed testbench for ext_mem_loader: sends command frames, logs the
// memory-port strobes and response bytes, and compares them against
// hand-computed values.
module tb_ext_mem_loader;

    logic        clk;
    logic        arst_n;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic [63:0] imem_addr;
    logic        imem_wen;
    logic        imem_ren;
    logic [31:0] imem_wdata;
    logic [63:0] dmem_addr;
    logic        dmem_wen;
    logic        dmem_ren;
    logic [63:0] dmem_wdata;
    logic [63:0] dmem_rdata;
    logic        cpu_enable;
    logic        busy;
    logic        err;

    int n_checks;
    int n_errors;

    logic [7:0]  tx_q[$];
    logic [7:0]  resp_q[$];
    logic [63:0] iaddr_q[$];
    logic [31:0] idata_q[$];
    logic [63:0] daddr_q[$];
    logic [63:0] ddata_q[$];
    logic [63:0] raddr_q[$];
    int          en_cycles;
    int          en_rises;
    int          strobe_clash;
    int          stall_cycles;
    int          stall_glitch;
    logic        prev_en;
    logic        prev_stalled;
    logic [7:0]  prev_data;
    logic [63:0] rd_addr;

    ext_mem_loader #(.IMEM_AW(9), .DMEM_AW(10)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .imem_addr  (imem_addr),
        .imem_wen   (imem_wen),
        .imem_ren   (imem_ren),
        .imem_wdata (imem_wdata),
        .dmem_addr  (dmem_addr),
        .dmem_wen   (dmem_wen),
        .dmem_ren   (dmem_ren),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .cpu_enable (cpu_enable),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Observe the ports mid-cycle; a handshake seen here completes on the next edge.
    always @(negedge clk) begin
        if (imem_wen) begin
            iaddr_q.push_back(imem_addr);
            idata_q.push_back(imem_wdata);
        end
        if (dmem_wen) begin
            daddr_q.push_back(dmem_addr);
            ddata_q.push_back(dmem_wdata);
        end
        if (dmem_ren) raddr_q.push_back(dmem_addr);
        if (m_valid && m_ready) resp_q.push_back(m_data);
        if (cpu_enable) en_cycles++;
        if (cpu_enable && !prev_en) en_rises++;
        prev_en = cpu_enable;
        if (32'($countones({imem_wen, dmem_wen, dmem_ren})) > 1) strobe_clash++;
        if (prev_stalled && (!m_valid || m_data != prev_data)) stall_glitch++;
        if (m_valid && !m_ready) stall_cycles++;
        prev_stalled = m_valid && !m_ready;
        prev_data    = m_data;
    end

    // DMEM read model: data appears the cycle after the read strobe, junk otherwise.
    always @(negedge clk) begin
        if (dmem_ren) begin
            rd_addr = dmem_addr;
            @(posedge clk);
            #1 dmem_rdata = (rd_addr == 64'h18) ? 64'h1122334455667788 : 64'h0;
            @(posedge clk);
            #1 dmem_rdata = 64'hBAD0BAD0BAD0BAD0;
        end
    end

    task automatic clear_logs();
        resp_q.delete();
        iaddr_q.delete();
        idata_q.delete();
        daddr_q.delete();
        ddata_q.delete();
        raddr_q.delete();
        en_cycles    = 0;
        en_rises     = 0;
        stall_cycles = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            $display("FAIL s_ready_timeout: got 0, expected 1 (byte %h)", b);
            $fatal(1, "s_ready timeout");
        end
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic send_tx();
        foreach (tx_q[i]) send_byte(tx_q[i]);
    endtask

    task automatic wait_resp(input string tag, input int n);
        int t;
        t = 0;
        while (resp_q.size() < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check_eq(tag, 64'(resp_q.size()), 64'(n));
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        arst_n       = 1'b0;
        s_valid      = 1'b0;
        s_data       = 8'd0;
        m_ready      = 1'b1;
        dmem_rdata   = 64'd0;
        prev_en      = 1'b0;
        prev_stalled = 1'b0;
        prev_data    = 8'd0;
        strobe_clash = 0;
        stall_glitch = 0;
        clear_logs();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_ctrl", 64'({s_ready, m_valid, m_data, imem_wen, imem_ren, dmem_wen,
                                    dmem_ren, cpu_enable, busy, err}), 64'd0);
        check_eq("reset_iaddr", imem_addr, 64'd0);
        check_eq("reset_idata", 64'(imem_wdata), 64'd0);
        check_eq("reset_daddr", dmem_addr, 64'd0);
        check_eq("reset_ddata", dmem_wdata, 64'd0);
        arst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_s_ready", 64'(s_ready), 64'd1);

        // Load IMEM, two words from index 0
        clear_logs();
        tx_q = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00,
                 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        send_tx();
        wait_resp("limem_resp_n", 1);
        check_eq("limem_resp", 64'(resp_q[0]), 64'hA5);
        check_eq("limem_wr_n", 64'(iaddr_q.size()), 64'd2);
        check_eq("limem_addr0", iaddr_q[0], 64'h0);
        check_eq("limem_data0", 64'(idata_q[0]), 64'h00000013);
        check_eq("limem_addr1", iaddr_q[1], 64'h4);
        check_eq("limem_data1", 64'(idata_q[1]), 64'h00100093);
        check_eq("limem_no_dwr", 64'(daddr_q.size()), 64'd0);
        check_eq("limem_busy", 64'(busy), 64'd0);

        // Load DMEM starting at the last word, wrapping to word 0
        clear_logs();
        tx_q = '{8'h02, 8'h02, 8'h00, 8'hFF, 8'h03,
                 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
        send_tx();
        wait_resp("ldmem_resp_n", 1);
        check_eq("ldmem_resp", 64'(resp_q[0]), 64'hA5);
        check_eq("ldmem_wr_n", 64'(daddr_q.size()), 64'd2);
        check_eq("ldmem_addr0", daddr_q[0], 64'h1FF8);
        check_eq("ldmem_data0", ddata_q[0], 64'h0807060504030201);
        check_eq("ldmem_addr1", daddr_q[1], 64'h0);
        check_eq("ldmem_data1", ddata_q[1], 64'h1817161514131211);
        check_eq("ldmem_no_iwr", 64'(iaddr_q.size()), 64'd0);

        // Run for 5 cycles
        clear_logs();
        tx_q = '{8'h03, 8'h05, 8'h00, 8'h00, 8'h00};
        send_tx();
        @(negedge clk);
        check_eq("run_en_mid", 64'(cpu_enable), 64'd1);
        check_eq("run_busy_mid", 64'(busy), 64'd1);
        wait_resp("run_resp_n", 1);
        check_eq("run_resp", 64'(resp_q[0]), 64'hA5);
        check_eq("run_en_cycles", 64'(en_cycles), 64'd5);
        check_eq("run_en_rises", 64'(en_rises), 64'd1);
        check_eq("run_busy_after", 64'(busy), 64'd0);
        check_eq("run_en_after", 64'(cpu_enable), 64'd0);

        // Dump word 3 with a 3-cycle stall partway through the bytes
        clear_logs();
        tx_q = '{8'h04, 8'h01, 8'h00, 8'h03, 8'h00};
        fork
            send_tx();
            begin
                int t;
                t = 0;
                while (resp_q.size() < 3 && t < 2000) begin
                    @(negedge clk);
                    t++;
                end
                @(posedge clk);
                #1 m_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 m_ready = 1'b1;
            end
        join
        wait_resp("dump_resp_n", 9);
        begin
            logic [7:0] exp_bytes [9];
            exp_bytes = '{8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'hA5};
            for (int i = 0; i < 9; i++) begin
                check_eq($sformatf("dump_byte%0d", i), 64'(resp_q[i]), 64'(exp_bytes[i]));
            end
        end
        check_eq("dump_rd_n", 64'(raddr_q.size()), 64'd1);
        check_eq("dump_rd_addr", raddr_q[0], 64'h18);
        check_eq("dump_stall_cycles", 64'(stall_cycles), 64'd3);
        check_eq("dump_stall_stable", 64'(stall_glitch), 64'd0);

        // Bad opcode, then a zero-count load
        clear_logs();
        tx_q = '{8'h07};
        send_tx();
        wait_resp("bad_resp_n", 1);
        check_eq("bad_resp", 64'(resp_q[0]), 64'hEE);
        check_eq("bad_err", 64'(err), 64'd1);
        check_eq("bad_busy", 64'(busy), 64'd0);
        clear_logs();
        tx_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        send_tx();
        wait_resp("cnt0_resp_n", 1);
        check_eq("cnt0_resp", 64'(resp_q[0]), 64'hA5);
        check_eq("cnt0_no_wr", 64'(iaddr_q.size()), 64'd0);
        check_eq("cnt0_err_sticky", 64'(err), 64'd1);

        // Reset partway through a load payload
        clear_logs();
        tx_q = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
        send_tx();
        @(negedge clk);
        arst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_mid_ctrl", 64'({s_ready, m_valid, m_data, imem_wen, imem_ren, dmem_wen,
                                      dmem_ren, cpu_enable, busy, err}), 64'd0);
        check_eq("rst_mid_iaddr", imem_addr, 64'd0);
        check_eq("rst_mid_idata", 64'(imem_wdata), 64'd0);
        arst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_mid_no_wr", 64'(iaddr_q.size()), 64'd0);
        check_eq("rst_mid_no_resp", 64'(resp_q.size()), 64'd0);
        tx_q = '{8'h01, 8'h01, 8'h00, 8'h05, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
        send_tx();
        wait_resp("rst_new_resp_n", 1);
        check_eq("rst_new_resp", 64'(resp_q[0]), 64'hA5);
        check_eq("rst_new_wr_n", 64'(iaddr_q.size()), 64'd1);
        check_eq("rst_new_addr", iaddr_q[0], 64'h14);
        check_eq("rst_new_data", 64'(idata_q[0]), 64'h11223344);

        check_eq("strobe_exclusive", 64'(strobe_clash), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
